weight_comp_stream_feeder: RTL and testbench

- Transmit-side driver for a chain of universal weight computation cells.
- Accepts input vectors from a valid/ready source, one chunk of INPUT_AMOUNT values per beat, and buffers them in a small FIFO.
- Emits the index/value/enable/result stream that the first cell of the chain consumes.
- Sequences one frame of num_vectors vectors, waits for the chain to drain, then pulses done.

---
 rtl/weight_comp_stream_feeder_pkg.sv | 21 ++
 rtl/weight_comp_stream_feeder_fifo.sv | 45 ++++
 rtl/weight_comp_stream_feeder.sv | 145 ++++++++++++++
 tb/tb_weight_comp_stream_feeder.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/weight_comp_stream_feeder_pkg.sv
// Shared types and derived constants for the weight-computation stream feeder.
package weight_comp_stream_feeder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } feeder_state_e;

    // Chunks per vector; WEIGHT_AMOUNT must be a multiple of INPUT_AMOUNT.
    function automatic int calc_chunks(input int weight_amount, input int input_amount);
        return weight_amount / input_amount;
    endfunction

    // The MSB of the result bus flags a valid result.
    function automatic int result_flag_bit(input int result_width);
        return result_width;
    endfunction

endpackage

// File: rtl/weight_comp_stream_feeder_fifo.sv
// Synchronous chunk FIFO; an extra pointer bit separates full from empty.
module feeder_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic             do_push, do_pop;

    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign dout    = mem_q[rd_q[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign wr_d    = do_push ? wr_q + 1'b1 : wr_q;
    assign rd_d    = do_pop  ? rd_q + 1'b1 : rd_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage carries no reset; stale entries are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/weight_comp_stream_feeder.sv
// Buffers source chunks and drives the first cell of a weight-computation chain,
// sequencing one frame of vectors, draining the chain, then pulsing done.
module weight_comp_stream_feeder
    import weight_comp_stream_feeder_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int RESULT_WIDTH  = 16,
    parameter int WEIGHT_AMOUNT = 4,
    parameter int INPUT_AMOUNT  = 4,
    parameter int CHAIN_LENGTH  = 4,
    parameter int FIFO_DEPTH    = 4,
    parameter int COUNT_WIDTH   = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [COUNT_WIDTH-1:0]           num_vectors,
    output logic                             busy,
    output logic                             done,
    input  logic [INPUT_AMOUNT*DATA_WIDTH-1:0] s_data,
    input  logic                             s_valid,
    output logic                             s_ready,
    output logic [DATA_WIDTH-1:0]            out_index,
    output logic [INPUT_AMOUNT*DATA_WIDTH-1:0] out_value,
    output logic [RESULT_WIDTH:0]            out_result,
    output logic                             out_enable
);
    localparam int CHUNKS = calc_chunks(WEIGHT_AMOUNT, INPUT_AMOUNT);
    localparam int CW     = INPUT_AMOUNT * DATA_WIDTH;
    localparam int TW     = COUNT_WIDTH + $clog2(CHUNKS) + 1;
    localparam int DRW    = $clog2(CHAIN_LENGTH + 2);

    feeder_state_e          state_q, state_d;
    logic [COUNT_WIDTH-1:0] num_q, num_d;
    logic [COUNT_WIDTH-1:0] vec_q, vec_d;
    logic [TW-1:0]          total_q, total_d;
    logic [TW-1:0]          acc_q, acc_d;
    logic [DATA_WIDTH-1:0]  idx_q, idx_d;
    logic [DRW-1:0]         drain_q, drain_d;

    logic                   en_q;
    logic [DATA_WIDTH-1:0]  oidx_q;
    logic [CW-1:0]          oval_q;

    logic                   fifo_full, fifo_empty;
    logic [CW-1:0]          fifo_dout;
    logic                   push, pop, last_pop;

    feeder_fifo #(
        .WIDTH (CW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (s_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign s_ready    = (state_q == ST_STREAM) && !fifo_full && (acc_q < total_q);
    assign push       = s_valid && s_ready;
    assign pop        = (state_q == ST_STREAM) && !fifo_empty;
    assign last_pop   = pop && (idx_q == DATA_WIDTH'(CHUNKS - 1))
                            && (vec_q == num_q - COUNT_WIDTH'(1));
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign out_enable = en_q;
    assign out_index  = oidx_q;
    assign out_value  = oval_q;
    assign out_result = '0;

    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        vec_d   = vec_q;
        total_d = total_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        drain_d = drain_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    num_d   = num_vectors;
                    total_d = TW'(num_vectors) * TW'(CHUNKS);
                    acc_d   = '0;
                    vec_d   = '0;
                    idx_d   = '0;
                    state_d = (num_vectors == '0) ? ST_DONE : ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (push) acc_d = acc_q + TW'(1);
                if (pop) begin
                    if (idx_q == DATA_WIDTH'(CHUNKS - 1)) begin
                        idx_d = '0;
                        vec_d = vec_q + COUNT_WIDTH'(1);
                    end else begin
                        idx_d = idx_q + DATA_WIDTH'(1);
                    end
                end
                if (last_pop) begin
                    state_d = ST_DRAIN;
                    drain_d = DRW'(CHAIN_LENGTH + 1);
                end
            end
            ST_DRAIN: begin
                // Leave once the count reaches zero: CHAIN_LENGTH+1 drain cycles.
                drain_d = drain_q - DRW'(1);
                if (drain_q <= DRW'(1)) state_d = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            num_q   <= '0;
            vec_q   <= '0;
            total_q <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
            drain_q <= '0;
            en_q    <= 1'b0;
            oidx_q  <= '0;
            oval_q  <= '0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            vec_q   <= vec_d;
            total_q <= total_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            drain_q <= drain_d;
            en_q    <= pop;
            oidx_q  <= pop ? idx_q : '0;
            oval_q  <= pop ? fifo_dout : '0;
        end
    end

endmodule

// File: tb/tb_weight_comp_stream_feeder.sv
// Directed bench: cycle table for one frame plus hand sequences for corner cases.
module tb_weight_comp_stream_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] num_vectors;
    logic        busy, done;
    logic [31:0] s_data;
    logic        s_valid, s_ready;
    logic [7:0]  out_index;
    logic [31:0] out_value;
    logic [16:0] out_result;
    logic        out_enable;

    int checks = 0;
    int errors = 0;

    weight_comp_stream_feeder #(
        .DATA_WIDTH    (8),
        .RESULT_WIDTH  (16),
        .WEIGHT_AMOUNT (8),
        .INPUT_AMOUNT  (4),
        .CHAIN_LENGTH  (4),
        .FIFO_DEPTH    (2),
        .COUNT_WIDTH   (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .num_vectors (num_vectors),
        .busy        (busy),
        .done        (done),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .out_index   (out_index),
        .out_value   (out_value),
        .out_result  (out_result),
        .out_enable  (out_enable)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic [15:0] nv;
        logic        sv;
        logic [31:0] sd;
        logic        e_en;
        logic [7:0]  e_idx;
        logic [31:0] e_val;
        logic        e_busy;
        logic        e_done;
        logic        e_rdy;
    } vec_t;

    vec_t tbl [12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, " en"},    64'(out_enable), 64'd0);
        chk({tag, " idx"},   64'(out_index),  64'd0);
        chk({tag, " val"},   64'(out_value),  64'd0);
        chk({tag, " res"},   64'(out_result), 64'd0);
        chk({tag, " busy"},  64'(busy),       64'd0);
        chk({tag, " done"},  64'(done),       64'd0);
        chk({tag, " rdy"},   64'(s_ready),    64'd0);
    endtask

    // Runs one frame with a source that raises valid every (gap+1) cycles and
    // holds it until accepted; checks emitted order, indices, gaps and done.
    task automatic run_frame(input int nv, input int gap, input bit poke, input string tag);
        logic [31:0] src [$];
        int total, sent, emitted, dones, cyc, after;
        bit fire, pend, finished;
        total = nv * 2; sent = 0; emitted = 0; dones = 0; cyc = 0; after = 0;
        pend = 0; finished = 0;
        for (int k = 0; k < total + 2; k++)
            src.push_back({8'(nv), 8'(gap), 8'(k), 8'hA5 ^ 8'(k)});
        start = 1'b1; num_vectors = 16'(nv); s_valid = 1'b0; s_data = '0;
        tick();
        start = 1'b0;
        while (!finished && cyc < 300) begin
            if (!pend && sent < src.size() && (cyc % (gap + 1)) == 0) pend = 1;
            s_valid     = pend;
            s_data      = pend ? src[sent] : 32'h0;
            start       = poke && (cyc == 1 || cyc == 6);
            num_vectors = 16'(nv + 7);
            fire        = s_valid && s_ready;
            tick();
            if (fire) begin
                sent++;
                pend = 0;
            end
            if (out_enable) begin
                chk({tag, " value"}, 64'(out_value), 64'(src[emitted]));
                chk({tag, " index"}, 64'(out_index), 64'(emitted % 2));
                emitted++;
            end else begin
                chk({tag, " gap zero"}, {24'h0, out_index, out_value}, 64'd0);
            end
            if (done) dones++;
            if (dones > 0) after++;
            if (after == 3) finished = 1;
            cyc++;
        end
        start = 1'b0; s_valid = 1'b0; s_data = '0;
        chk({tag, " timeout"}, 64'(finished), 64'd1);
        chk({tag, " emitted"}, 64'(emitted), 64'(total));
        chk({tag, " accepted"}, 64'(sent), 64'(total));
        chk({tag, " dones"}, 64'(dones), 64'd1);
        chk({tag, " busy end"}, 64'(busy), 64'd0);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 16'd2, 1'b0, 32'h0,        1'b0, 8'd0, 32'h0,        1'b1, 1'b0, 1'b1};
        tbl[1]  = '{1'b0, 16'd2, 1'b1, 32'h11223344, 1'b0, 8'd0, 32'h0,        1'b1, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 16'd2, 1'b1, 32'h55667788, 1'b1, 8'd0, 32'h11223344, 1'b1, 1'b0, 1'b1};
        tbl[3]  = '{1'b0, 16'd2, 1'b1, 32'h99AABBCC, 1'b1, 8'd1, 32'h55667788, 1'b1, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 16'd2, 1'b1, 32'hDDEEFF00, 1'b1, 8'd0, 32'h99AABBCC, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 16'd2, 1'b1, 32'hEEEEEEEE, 1'b1, 8'd1, 32'hDDEEFF00, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 16'd2, 1'b0, 32'h0,        1'b0, 8'd0, 32'h0,        1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 16'd2, 1'b0, 32'h0,        1'b0, 8'd0, 32'h0,        1'b1, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 16'd2, 1'b0, 32'h0,        1'b0, 8'd0, 32'h0,        1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 16'd2, 1'b0, 32'h0,        1'b0, 8'd0, 32'h0,        1'b1, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 16'd2, 1'b0, 32'h0,        1'b0, 8'd0, 32'h0,        1'b1, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 16'd2, 1'b0, 32'h0,        1'b0, 8'd0, 32'h0,        1'b0, 1'b0, 1'b0};

        rst = 1'b1; start = 1'b0; num_vectors = '0; s_valid = 1'b0; s_data = '0;
        tick();
        tick();
        chk_idle_outputs("reset");
        rst = 1'b0;
        tick();

        // Two-vector frame, source always valid.
        for (int i = 0; i < 12; i++) begin
            start       = tbl[i].start;
            num_vectors = tbl[i].nv;
            s_valid     = tbl[i].sv;
            s_data      = tbl[i].sd;
            tick();
            chk($sformatf("row%0d en", i),   64'(out_enable), 64'(tbl[i].e_en));
            chk($sformatf("row%0d idx", i),  64'(out_index),  64'(tbl[i].e_idx));
            chk($sformatf("row%0d val", i),  64'(out_value),  64'(tbl[i].e_val));
            chk($sformatf("row%0d busy", i), 64'(busy),       64'(tbl[i].e_busy));
            chk($sformatf("row%0d done", i), 64'(done),       64'(tbl[i].e_done));
            chk($sformatf("row%0d rdy", i),  64'(s_ready),    64'(tbl[i].e_rdy));
            chk($sformatf("row%0d res", i),  64'(out_result), 64'd0);
        end
        start = 1'b0; s_valid = 1'b0;

        // Empty frame: straight to DONE, then IDLE.
        start = 1'b1; num_vectors = 16'd0;
        tick();
        start = 1'b0;
        chk("nv0 done",  64'(done),       64'd1);
        chk("nv0 busy",  64'(busy),       64'd1);
        chk("nv0 rdy",   64'(s_ready),    64'd0);
        chk("nv0 en",    64'(out_enable), 64'd0);
        tick();
        chk("nv0 done clr", 64'(done), 64'd0);
        chk("nv0 busy clr", 64'(busy), 64'd0);

        run_frame(3, 0, 1'b0, "b2b");
        run_frame(2, 2, 1'b0, "bursty");
        run_frame(2, 0, 1'b1, "poke");

        // Reset in the middle of a frame with chunks in flight.
        start = 1'b1; num_vectors = 16'd3;
        tick();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            s_valid = 1'b1; s_data = 32'hDEAD0000 | 32'(k);
            tick();
        end
        rst = 1'b1; s_valid = 1'b0; s_data = '0;
        tick();
        chk_idle_outputs("midrst");
        rst = 1'b0;
        tick();
        chk_idle_outputs("postrst");
        run_frame(1, 0, 1'b0, "afterrst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
